panda_lsu_ctrl: RTL and testbench
=================================

// Module: panda_lsu_ctrl
// PURPOSE
// - Load/store sequencer between the execute stage and the data-memory bus (req/gnt/rvalid protocol).
// - Takes the decoded LSU controls (store, width, load_unsigned) and the ALU-computed address, and drives one bus transaction per request.
// - Formats store data and byte enables, and sign/zero-extends load data.
// - Stalls the core until the transaction completes, errors or times out.
// PARAMETERS
// - TIMEOUT_CYCLES  default 255  max cycles spent in WAIT_GNT+WAIT_RVALID before abort; 0 disables the timeout
// PORTS
// - clk_i                input   1   clock, all state on rising edge
// - rst_i                input   1   reset, synchronous, active-high
// - lsu_req_i            input   1   level; memory instruction in MEM stage, held until lsu_done_o
// - lsu_store_i          input   1   1=store, 0=load
// - lsu_width_i          input   2   00 byte, 01 half, 10 word, 11 illegal
// - lsu_load_unsigned_i  input   1   1=zero-extend load, 0=sign-extend
// - lsu_addr_i           input   32  byte address
// - lsu_wdata_i          input   32  store data (rs2)
// - lsu_stall_o          output  1   lsu_req_i & ~lsu_done_o
// - lsu_done_o           output  1   1-cycle completion pulse
// - lsu_rdata_o          output  32  formatted load data, valid with lsu_done_o
// - lsu_err_o            output  1   bus timeout or illegal width, valid with lsu_done_o
// - lsu_misaligned_o     output  1   misaligned abort, valid with lsu_done_o
// - data_req_o           output  1   bus request
// - data_gnt_i           input   1   bus grant
// - data_we_o            output  1   bus write enable
// - data_be_o            output  4   byte enables
// - data_addr_o          output  32  word-aligned address {addr[31:2],2'b00}
// - data_wdata_o         output  32  lane-replicated store data
// - data_rvalid_i        input   1   response valid (loads and stores)
// - data_rdata_i         input   32  response data
// BEHAVIOUR
// - Reset: state=IDLE, counter=0; all outputs 0 (lsu_stall_o follows lsu_req_i).
// - FSM states: IDLE, WAIT_GNT, WAIT_RVALID, DONE.
// - IDLE & lsu_req_i: latch addr/we/be/wdata/width/unsigned -> WAIT_GNT.
//   - Width 11 goes to DONE with err=1 and no bus request.
// - WAIT_GNT: data_req_o=1; addr/we/be/wdata held stable; data_gnt_i -> WAIT_RVALID.
// - WAIT_RVALID: data_req_o=0; data_rvalid_i -> DONE, with rdata formatted and registered.
// - DONE: lsu_done_o=1 for exactly one cycle -> IDLE; new request accepted no earlier than the next cycle.
// - Minimum latency, accept to done: 3 cycles (gnt in the first WAIT_GNT cycle, rvalid the next cycle).
// - Byte access:
//   - be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
//   - Load takes lane addr[1:0], then sign/zero-extends 8->32.
// - Half access:
//   - be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
//   - Load takes lane addr[1], then sign/zero-extends 16->32.
// - Word access: be = 4'b1111; data passed through unchanged.
// - Stores: lsu_rdata_o = 0; completion still waits for data_rvalid_i.
// - Timeout: counter clears on accept and increments each cycle in WAIT_GNT or WAIT_RVALID.
//   - When counter == TIMEOUT_CYCLES: data_req_o drops, go to DONE with err=1 and rdata=0.
// - Spurious events:
//   - data_rvalid_i in IDLE, WAIT_GNT or DONE is ignored.
//   - data_gnt_i outside WAIT_GNT is ignored.
// - rst_i mid-transaction: IDLE on the next edge, data_req_o=0, no lsu_done_o pulse.
// CONFIGURATION
// - PANDA_LSU_MISALIGN_EN defined:
//   - Half access with addr[0]=1, or word access with addr[1:0]!=0, issues no bus request.
//   - Goes IDLE->DONE with lsu_misaligned_o=1, err=0, rdata=0.
// - PANDA_LSU_MISALIGN_EN undefined:
//   - lsu_misaligned_o tied 0.
//   - Offending low address bits are ignored (half uses addr[1] only; word uses none).
// TESTING
// - LB: addr=0x1003, rdata=0x80FF_FF00, unsigned=0, gnt/rvalid immediate -> done on 3rd cycle, rdata_o=0xFFFF_FF80, be seen=4'b1000.
// - SH: addr=0x2002, wdata=0x0000_BEEF -> data_be_o=4'b1100, data_wdata_o=0xBEEF_BEEF, data_we_o=1, addr=0x2000.
// - Grant stall: gnt held low 5 cycles -> req and addr stable throughout, stall_o=1 until done; LHU rdata 0xABCD_1234 addr[1]=1 -> 0x0000_ABCD.
// - Timeout: TIMEOUT_CYCLES=4, gnt never -> done+err=1 after 4 cycles in WAIT_GNT, req drops; later rvalid ignored.
// - Width 11 -> done+err next cycle, no data_req_o; rst_i asserted in WAIT_RVALID -> req_o 0, no done pulse.
// - LW at 0x1002: with PANDA_LSU_MISALIGN_EN -> misaligned_o=1, no request; without -> bus addr 0x1000, normal load.

Source files
------------

// File: rtl/panda_lsu_ctrl.sv
// Load/store sequencer between the execute stage and a req/gnt/rvalid data bus.
// Optional feature macro: PANDA_LSU_MISALIGN_EN (abort misaligned half/word accesses without a bus request).
module panda_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_store_i,
  input  logic [1:0]  lsu_width_i,
  input  logic        lsu_load_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        lsu_misaligned_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 32'd0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_RVALID, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        off_q, off_d, width_q, width_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d, uns_q, uns_d, err_q, err_d, mis_q, mis_d;
  logic              req_q, req_d, done_q, done_d;
  logic              misalign_s, timeout_s;

  function automatic logic [3:0] be_of(input logic [1:0] w, input logic [1:0] off);
    logic [3:0] be;
    case (w)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] w, input logic [31:0] wd);
    logic [31:0] r;
    case (w)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] w, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (w)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      2'b10:   r = rd;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

`ifdef PANDA_LSU_MISALIGN_EN
  assign misalign_s = ((lsu_width_i == 2'b01) && lsu_addr_i[0]) ||
                      ((lsu_width_i == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign timeout_s = TO_EN && (cnt_q == TO_VAL);

  // Next-state, transaction latching and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    width_d = width_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_req_i) begin
          cnt_d   = {CNT_W{1'b0}};
          addr_d  = {lsu_addr_i[31:2], 2'b00};
          off_d   = lsu_addr_i[1:0];
          we_d    = lsu_store_i;
          be_d    = be_of(lsu_width_i, lsu_addr_i[1:0]);
          wdata_d = wdata_of(lsu_width_i, lsu_wdata_i);
          width_d = lsu_width_i;
          uns_d   = lsu_load_unsigned_i;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          if (lsu_width_i == 2'b11) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (misalign_s) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_GNT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_GNT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_s) begin
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
          state_d = S_DONE;
        end else if (data_gnt_i) begin
          state_d = S_WAIT_RVALID;
        end else begin
          state_d = S_WAIT_GNT;
        end
      end
      S_WAIT_RVALID: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_s) begin
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
          state_d = S_DONE;
        end else if (data_rvalid_i) begin
          rdata_d = we_q ? 32'h0000_0000 : load_fmt(width_q, uns_q, off_q, data_rdata_i);
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_RVALID;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Request and done are decoded from the next state so both leave a flop.
    req_d  = (state_d == S_WAIT_GNT) && !(TO_EN && (cnt_d == TO_VAL));
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= 32'h0000_0000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  assign lsu_done_o       = done_q;
  assign lsu_stall_o      = lsu_req_i & ~done_q;
  assign lsu_rdata_o      = rdata_q;
  assign lsu_err_o        = err_q;
  assign lsu_misaligned_o = mis_q;
  assign data_req_o       = req_q;
  assign data_we_o        = we_q;
  assign data_be_o        = be_q;
  assign data_addr_o      = addr_q;
  assign data_wdata_o     = wdata_q;

endmodule

// File: tb/tb_panda_lsu_ctrl.sv
// Randomized self-checking bench for panda_lsu_ctrl against a cycle-count reference model.
module tb_panda_lsu_ctrl;

  localparam int TO = 8;
`ifdef PANDA_LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_req_i = 1'b0, lsu_store_i = 1'b0, lsu_load_unsigned_i = 1'b0;
  logic [1:0]  lsu_width_i = 2'b00;
  logic [31:0] lsu_addr_i = 32'h0, lsu_wdata_i = 32'h0;
  logic        lsu_stall_o, lsu_done_o, lsu_err_o, lsu_misaligned_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_we_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [31:0] data_rdata_i = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  panda_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_store_i(lsu_store_i), .lsu_width_i(lsu_width_i),
    .lsu_load_unsigned_i(lsu_load_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o), .lsu_misaligned_o(lsu_misaligned_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] w, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (w == 2'b00) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'b01) begin
      v = (rd >> (16 * int'(a[1]))) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b00) return 32'd1 << int'(a[1:0]);
    if (w == 2'b01) return 32'd3 << (2 * int'(a[1]));
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] w, input logic [31:0] wd);
    if (w == 2'b00) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (w == 2'b01) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lsu_req_i     = 1'b0;
      data_gnt_i    = 1'($urandom_range(0, 1));
      data_rvalid_i = 1'($urandom_range(0, 1));
      data_rdata_i  = $urandom;
      #1;
      check_eq("idle_done",  32'(lsu_done_o),  32'd0);
      check_eq("idle_req",   32'(data_req_o),  32'd0);
      check_eq("idle_stall", 32'(lsu_stall_o), 32'd0);
    end
  endtask

  // Cycle 0 is the accept cycle; grant lands in cycle g, response in cycle r.
  task automatic run_txn(input logic st, input logic [1:0] w, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rdl, input logic [31:0] rdat);
    bit  mis, abort;
    int  g, r, done_c, req_last;
    logic [31:0] e_rdata;
    bit  e_err;
    mis   = MIS_EN && (((w == 2'b01) && a[0]) || ((w == 2'b10) && (a[1:0] != 2'b00)));
    abort = (w == 2'b11) || mis;
    g = 1 + gd;
    r = g + 1 + rdl;
    if (abort) begin
      done_c = 1; e_err = (w == 2'b11); e_rdata = 32'h0; req_last = 0;
    end else if (r <= TO) begin
      done_c = r + 1; e_err = 1'b0; e_rdata = st ? 32'h0 : ref_load(w, uns, a, rdat);
      req_last = g;
    end else begin
      done_c = TO + 2; e_err = 1'b1; e_rdata = 32'h0;
      req_last = (g < TO) ? g : TO;
    end
    for (int k = 0; k <= done_c; k++) begin
      @(negedge clk);
      if (k == 0) begin
        lsu_req_i = 1'b1; lsu_store_i = st; lsu_width_i = w;
        lsu_load_unsigned_i = uns; lsu_addr_i = a; lsu_wdata_i = wd;
      end
      if (abort) begin
        data_gnt_i    = 1'($urandom_range(0, 1));
        data_rvalid_i = 1'($urandom_range(0, 1));
      end else begin
        data_gnt_i    = (k == g) || ((k == 0 || k > g) && 1'($urandom_range(0, 1)));
        data_rvalid_i = (k == r) || ((k <= g || k >= done_c) && 1'($urandom_range(0, 1)));
      end
      data_rdata_i = (k == r) ? rdat : $urandom;
      #1;
      check_eq("req",   32'(data_req_o),  32'(k >= 1 && k <= req_last));
      check_eq("done",  32'(lsu_done_o),  32'(k == done_c));
      check_eq("stall", 32'(lsu_stall_o), 32'(k != done_c));
      if (k >= 1 && k <= req_last) begin
        check_eq("addr",  data_addr_o,       a & 32'hFFFF_FFFC);
        check_eq("be",    32'(data_be_o),    ref_be(w, a));
        check_eq("we",    32'(data_we_o),    32'(st));
        check_eq("wdata", data_wdata_o,      ref_wd(w, wd));
      end
      if (k == done_c) begin
        check_eq("rdata", lsu_rdata_o,             e_rdata);
        check_eq("err",   32'(lsu_err_o),          32'(e_err));
        check_eq("mis",   32'(lsu_misaligned_o),   32'(mis));
      end
    end
    idle_cycles($urandom_range(1, 3));
  endtask

  initial begin
    // Reset: outputs quiet while stall tracks the request level.
    repeat (2) @(negedge clk);
    lsu_req_i = 1'b1;
    #1;
    check_eq("rst_stall", 32'(lsu_stall_o), 32'd1);
    check_eq("rst_done",  32'(lsu_done_o),  32'd0);
    check_eq("rst_req",   32'(data_req_o),  32'd0);
    check_eq("rst_rdata", lsu_rdata_o,      32'd0);
    check_eq("rst_err",   32'(lsu_err_o),   32'd0);
    check_eq("rst_be",    32'(data_be_o),   32'd0);
    check_eq("rst_addr",  data_addr_o,      32'd0);
    @(negedge clk);
    lsu_req_i = 1'b0;
    rst_i = 1'b0;
    idle_cycles(2);

    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_FF00);
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 32'h0);
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'h0, 5, 0, 32'hABCD_1234);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 30, 0, 32'h1234_5678);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_4004, 32'h0, 2, 20, 32'h1234_5678);
    run_txn(1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0, 0, 0, 32'h0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 0, 1, 32'hCAFE_F00D);
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_1001, 32'h7777_8899, 1, 1, 32'h0);

    // Reset while waiting for the response: no completion pulse may follow.
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_store_i = 1'b0; lsu_width_i = 2'b10; lsu_addr_i = 32'h0000_6000;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(negedge clk);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    #1;
    check_eq("mid_req_wr", 32'(data_req_o), 32'd0);
    rst_i = 1'b1; lsu_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0; data_rvalid_i = 1'b1;
    #1;
    check_eq("mid_rst_req",  32'(data_req_o), 32'd0);
    check_eq("mid_rst_done", 32'(lsu_done_o), 32'd0);
    idle_cycles(3);

    for (int i = 0; i < 200; i++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom_range(0, 9), $urandom_range(0, 4), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
